// File: rtl/chacha_qr_pkg.sv
// chacha_qr_pkg
//   Shared constants, FSM state encoding and bus address helpers for the
//   ChaCha quarter-round host.
//   Address layout on the byte bus: {word[1:0], byte[1:0]}, word 0=a .. 3=d,
//   byte 0 = bits 7:0 of the word. The flat byte index equals the address.
package chacha_qr_pkg;

  localparam int NUM_BYTES = 16;
  localparam int ADDR_W    = 4;
  localparam int BYTE_W    = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_WRITE  = 3'd1;
  localparam state_t ST_VERIFY = 3'd2;
  localparam state_t ST_QR     = 3'd3;
  localparam state_t ST_QWAIT  = 3'd4;
  localparam state_t ST_READ   = 3'd5;
  localparam state_t ST_DONE   = 3'd6;

  function automatic logic [1:0] addr_word(input logic [ADDR_W-1:0] addr);
    return addr[3:2];
  endfunction

  function automatic logic [1:0] addr_byte(input logic [ADDR_W-1:0] addr);
    return addr[1:0];
  endfunction

  // Byte of a {d,c,b,a} state selected by a bus address.
  function automatic logic [BYTE_W-1:0] sel_byte(
    input logic [NUM_BYTES*BYTE_W-1:0] data,
    input logic [ADDR_W-1:0]           addr
  );
    return data[{addr_word(addr), addr_byte(addr), 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/chacha_qr_host.sv
// chacha_qr_host
//   Host-side master for the ChaCha quarter-round byte-bus peripheral.
//   Writes a 128-bit {d,c,b,a} state as 16 bytes, pulses bus_qr_en `rounds`
//   times (QR_WAIT idle cycles after each pulse), reads the 16 bytes back and
//   offers them on a valid/ready result port.
//
//   Optional feature macro: CHACHA_QR_HOST_VERIFY_EN
//     defined   -> VERIFY pass after WRITE reads every byte back and sets the
//                  sticky err flag on any mismatch
//     undefined -> no VERIFY pass, err tied to 0
//
//   Ports
//     clk, rst_n            clock, synchronous active-low reset
//     in_valid/in_ready     request handshake; in_data {d,c,b,a}, rounds
//     out_valid/out_ready   result handshake; out_data {d,c,b,a}
//     busy                  high in every state except IDLE
//     err                   sticky readback mismatch (verify builds only)
//     bus_addr/bus_wdata    peripheral address and write byte
//     bus_wr_en/bus_qr_en   peripheral write and quarter-round strobes
//     bus_rdata             peripheral read data (combinational on bus_addr)
//
//   state  | meaning
//   IDLE   | waiting for a request, in_ready=1
//   WRITE  | 16 byte writes, addr 0..15
//   VERIFY | 16 byte readbacks compared with the latched request
//   QR     | one-cycle quarter-round strobe
//   QWAIT  | QR_WAIT idle cycles after a strobe
//   READ   | 16 byte reads into out_data
//   DONE   | out_valid=1 until out_ready
import chacha_qr_pkg::*;

module chacha_qr_host #(
  parameter int QR_WAIT = 2,
  parameter int CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_BYTES*BYTE_W-1:0] in_data,
  input  logic [CNT_W-1:0]            rounds,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_BYTES*BYTE_W-1:0] out_data,
  output logic                        busy,
  output logic                        err,
  output logic [ADDR_W-1:0]           bus_addr,
  output logic [BYTE_W-1:0]           bus_wdata,
  output logic                        bus_wr_en,
  output logic                        bus_qr_en,
  input  logic [BYTE_W-1:0]           bus_rdata
);

  localparam int WAIT_W = (QR_WAIT > 1) ? $clog2(QR_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((QR_WAIT > 0) ? QR_WAIT - 1 : 0);

  state_t                      state, state_nxt;
  logic [ADDR_W-1:0]           idx, idx_nxt;
  logic [CNT_W-1:0]            rcnt, rcnt_nxt;
  logic [WAIT_W-1:0]           wcnt, wcnt_nxt;
  logic [NUM_BYTES*BYTE_W-1:0] data_q, data_nxt;
  logic                        accept;
  logic                        last_byte;
  state_t                      after_load;

  assign accept    = (state == ST_IDLE) && in_ready && in_valid;
  assign last_byte = (idx == ADDR_W'(NUM_BYTES - 1));
  // Where to go once the state is loaded, or after a wait: more strobes or readback.
  assign after_load = (rcnt == '0) ? ST_READ : ST_QR;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rcnt_nxt  = rcnt;
    wcnt_nxt  = wcnt;
    data_nxt  = data_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_WRITE;
          idx_nxt   = '0;
          rcnt_nxt  = rounds;
          data_nxt  = in_data;
        end
      end
      ST_WRITE: begin
        // idx wraps 15 -> 0, so the next byte phase starts at address 0.
        idx_nxt = idx + 1'b1;
        if (last_byte) begin
`ifdef CHACHA_QR_HOST_VERIFY_EN
          state_nxt = ST_VERIFY;
`else
          state_nxt = after_load;
`endif
        end
      end
      ST_VERIFY: begin
        idx_nxt = idx + 1'b1;
        if (last_byte) state_nxt = after_load;
      end
      ST_QR: begin
        rcnt_nxt = rcnt - 1'b1;
        if (QR_WAIT == 0) begin
          state_nxt = (rcnt == CNT_W'(1)) ? ST_READ : ST_QR;
        end else begin
          state_nxt = ST_QWAIT;
          wcnt_nxt  = WAIT_LOAD;
        end
      end
      ST_QWAIT: begin
        if (wcnt == '0) state_nxt = after_load;
        else            wcnt_nxt  = wcnt - 1'b1;
      end
      ST_READ: begin
        idx_nxt = idx + 1'b1;
        if (last_byte) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so that every bus
  // output lines up with the state it belongs to in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      rcnt      <= '0;
      wcnt      <= '0;
      data_q    <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wr_en <= 1'b0;
      bus_qr_en <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      rcnt      <= rcnt_nxt;
      wcnt      <= wcnt_nxt;
      data_q    <= data_nxt;
      in_ready  <= (state_nxt == ST_IDLE);
      busy      <= (state_nxt != ST_IDLE);
      out_valid <= (state_nxt == ST_DONE);
      bus_wr_en <= (state_nxt == ST_WRITE);
      bus_qr_en <= (state_nxt == ST_QR);
      bus_addr  <= (state_nxt == ST_WRITE || state_nxt == ST_VERIFY ||
                    state_nxt == ST_READ) ? idx_nxt : '0;
      bus_wdata <= (state_nxt == ST_WRITE) ? sel_byte(data_nxt, idx_nxt) : '0;
      if (state == ST_READ) out_data[{bus_addr, 3'b000} +: BYTE_W] <= bus_rdata;
    end
  end

`ifdef CHACHA_QR_HOST_VERIFY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                                     err <= 1'b0;
    else if (state == ST_VERIFY && bus_rdata != sel_byte(data_q, bus_addr)) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_chacha_qr_host.sv
// tb_chacha_qr_host
//   Directed bench for chacha_qr_host. The peripheral is modelled as a
//   16-byte register file with a ChaCha quarter-round applied on bus_qr_en;
//   expected results are hand-derived constants.
module tb_chacha_qr_host;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [7:0]   rounds = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;
  logic         err;
  logic [3:0]   bus_addr;
  logic [7:0]   bus_wdata;
  logic         bus_wr_en;
  logic         bus_qr_en;
  logic [7:0]   bus_rdata;

  int checks = 0;
  int failures = 0;

`ifdef CHACHA_QR_HOST_VERIFY_EN
  localparam int VOFF = 16;
`else
  localparam int VOFF = 0;
`endif

  localparam logic [127:0] VEC_SEQ = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] VEC_RFC_IN  = {32'h01234567, 32'h9b8d6f43, 32'h01020304, 32'h11111111};
  localparam logic [127:0] VEC_RFC_OUT = {32'h5881c4bb, 32'h4581472e, 32'hcb1cf8ce, 32'hea2a92f4};

  chacha_qr_host #(.QR_WAIT(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .rounds(rounds),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr_en(bus_wr_en),
    .bus_qr_en(bus_qr_en), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Peripheral model
  logic [127:0] pmem = '0;
  logic         corrupt = 1'b0;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] quarter_round(input logic [127:0] s);
    logic [31:0] a, b, c, d;
    {d, c, b, a} = s;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {d, c, b, a};
  endfunction

  always @(posedge clk) begin
    if (bus_wr_en)
      pmem[{bus_addr, 3'b000} +: 8] <= bus_wdata ^ ((corrupt && bus_addr == 4'd5) ? 8'hFF : 8'h00);
    if (bus_qr_en)
      pmem <= quarter_round(pmem);
  end

  assign bus_rdata = pmem[{bus_addr, 3'b000} +: 8];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it until out_valid (left asserted).
  task automatic do_req(input string name, input logic [127:0] d, input logic [7:0] r,
                        input logic [127:0] exp_out, input int exp_lat);
    int t_valid, qr_first, qr_cnt;
    logic wr_ok;
    t_valid = -1; qr_first = -1; qr_cnt = 0; wr_ok = 1'b1;
    @(negedge clk);
    chk({name, "_in_ready_pre"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1; in_data = d; rounds = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n < 1200; n++) begin
      if (n <= 16) begin
        if (!(bus_wr_en && bus_addr == 4'(n - 1) && bus_wdata == d[8*(n-1) +: 8])) wr_ok = 1'b0;
      end else if (bus_wr_en) wr_ok = 1'b0;
      if (bus_wr_en && bus_qr_en) wr_ok = 1'b0;
      if (bus_qr_en) begin
        if (qr_first < 0) qr_first = n;
        qr_cnt++;
      end
      if (out_valid) begin
        t_valid = n;
        break;
      end
      @(posedge clk); #1;
    end
    chk({name, "_write_seq"}, 128'(wr_ok), 128'(1));
    chk({name, "_latency"}, 128'(t_valid), 128'(exp_lat));
    chk({name, "_qr_count"}, 128'(qr_cnt), 128'(r));
    if (r != 0) chk({name, "_qr_first"}, 128'(qr_first), 128'(17 + VOFF));
    chk({name, "_out_data"}, out_data, exp_out);
  endtask

  task automatic handoff();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] held;
    int n;

    // 1. reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_low", 128'(in_ready), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_bus", 128'({bus_addr, bus_wdata, bus_wr_en, bus_qr_en}), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    // 2. rounds = 0, sequential bytes
    do_req("r0", VEC_SEQ, 8'd0, VEC_SEQ, 33 + VOFF);
    handoff();

    // 3. RFC 7539 quarter-round vector, one round
    do_req("rfc", VEC_RFC_IN, 8'd1, VEC_RFC_OUT, 36 + VOFF);

    // 4. backpressure in DONE with a new request pending
    held = out_data;
    @(negedge clk);
    in_valid = 1'b1; in_data = VEC_SEQ; rounds = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_data_stable", out_data, held);
      chk("bp_in_ready_low", 128'(in_ready), 128'(0));
      chk("bp_out_valid_held", 128'(out_valid), 128'(1));
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_handoff_valid", 128'(out_valid), 128'(0));
    chk("bp_handoff_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk); out_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp_accept_busy", 128'(busy), 128'(1));
    chk("bp_accept_in_ready", 128'(in_ready), 128'(0));
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_drain_valid", 128'(out_valid), 128'(1));
    chk("bp_drain_data", out_data, VEC_SEQ);
    handoff();

    // 5. reset during WRITE, then a fresh request
    @(negedge clk);
    in_valid = 1'b1; in_data = VEC_RFC_IN; rounds = 8'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("abort_in_write", 128'({bus_wr_en, bus_addr}), 128'({1'b1, 4'd7}));
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_wr_en", 128'(bus_wr_en), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    do_req("fresh", VEC_RFC_IN, 8'd1, VEC_RFC_OUT, 36 + VOFF);
    handoff();

    // all-zero state stays zero through any number of rounds
    do_req("r3", '0, 8'd3, '0, 33 + 9 + VOFF);
    handoff();
    do_req("r255", '0, 8'd255, '0, 33 + 255 * 3 + VOFF);
    handoff();
    chk("err_clean", 128'(err), 128'(0));

`ifdef CHACHA_QR_HOST_VERIFY_EN
    // 6. corrupted write is flagged and the flag is sticky
    corrupt = 1'b1;
    do_req("vfy", VEC_SEQ, 8'd0, VEC_SEQ ^ (128'hFF << 40), 33 + VOFF);
    corrupt = 1'b0;
    chk("vfy_err_done", 128'(err), 128'(1));
    handoff();
    chk("vfy_err_sticky", 128'(err), 128'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
